// File: rtl/max_pool_ctrl.sv
// max_pool_ctrl: max-pool window sequencer with argmax capture and gradient scatter.
// Optional MAX_POOL_CTRL_ZERO_FILL_EN: backward writes whole windows, zeros off argmax.
module max_pool_ctrl #(
  parameter int WIDTH  = 16,
  parameter int STRIDE = 2,
  parameter int IN_W   = 32,
  parameter int IN_H   = 32,
  localparam int OUT_W = IN_W / STRIDE,
  localparam int OUT_H = IN_H / STRIDE,
  localparam int N     = OUT_W * OUT_H,
  localparam int S2    = STRIDE * STRIDE,
  localparam int IA    = (IN_W * IN_H > 1) ? $clog2(IN_W * IN_H) : 1,
  localparam int OA    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             fm_rd_en,
  output logic [IA-1:0]    fm_rd_addr,
  input  logic [WIDTH-1:0] fm_rd_data,
  output logic             out_wr_en,
  output logic [OA-1:0]    out_wr_addr,
  output logic [WIDTH-1:0] out_wr_data,
  output logic             grad_rd_en,
  output logic [OA-1:0]    grad_rd_addr,
  input  logic [WIDTH-1:0] grad_rd_data,
  output logic             gin_wr_en,
  output logic [IA-1:0]    gin_wr_addr,
  output logic [WIDTH-1:0] gin_wr_data
);

  localparam int KW = (S2 > 1) ? $clog2(S2) : 1;

  typedef enum logic [2:0] {
    IDLE,
    F_READ,
    F_WAIT,
    F_WRITE,
    B_READ,
    B_WAIT,
    B_WRITE,
    FIN
  } state_t;

  state_t                  state;
  logic [OA-1:0]           win;
  logic [KW-1:0]           k;
  logic signed [WIDTH-1:0] mx;
  logic [KW-1:0]           kmx;
  logic                    fwd_op;
  logic                    fwd_valid;
  logic [KW-1:0]           amem [N];
  logic [KW-1:0]           am;
`ifdef MAX_POOL_CTRL_ZERO_FILL_EN
  logic [WIDTH-1:0]        gval;
`endif

  logic signed [WIDTH-1:0] din;
  logic [KW-1:0]           ce;
  logic                    cmp_on;
  logic signed [WIDTH-1:0] nmx;
  logic [KW-1:0]           nkmx;

  // Raster input address of element e of output window w.
  function automatic logic [IA-1:0] in_addr(
    input logic [OA-1:0] w,
    input logic [KW-1:0] e
  );
    int r;
    int c;
    int kr;
    int kc;
    r  = int'(w) / OUT_W;
    c  = int'(w) % OUT_W;
    kr = int'(e) / STRIDE;
    kc = int'(e) % STRIDE;
    return IA'((r * STRIDE + kr) * IN_W + c * STRIDE + kc);
  endfunction

  assign din = $signed(fm_rd_data);
  assign am  = amem[win];

  // Running max: the element read last cycle seeds (k=0) or replaces on strictly greater.
  always_comb begin
    ce     = k - 1'b1;
    cmp_on = 1'b0;
    nmx    = mx;
    nkmx   = kmx;
    if (state == F_READ) begin
      ce     = k - 1'b1;
      cmp_on = (k != '0);
    end else if (state == F_WAIT) begin
      ce     = k;
      cmp_on = 1'b1;
    end
    if (cmp_on && ((ce == '0) || (din > mx))) begin
      nmx  = din;
      nkmx = ce;
    end
  end

  // Argmax memory: no reset, every forward pass rewrites all entries.
  always_ff @(posedge clk) begin
    if (state == F_WRITE)
      amem[win] <= kmx;
  end

  // Main sequencer with registered strobes, addresses and data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      win          <= '0;
      k            <= '0;
      mx           <= '0;
      kmx          <= '0;
      fwd_op       <= 1'b0;
      fwd_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      fm_rd_en     <= 1'b0;
      fm_rd_addr   <= '0;
      out_wr_en    <= 1'b0;
      out_wr_addr  <= '0;
      out_wr_data  <= '0;
      grad_rd_en   <= 1'b0;
      grad_rd_addr <= '0;
      gin_wr_en    <= 1'b0;
      gin_wr_addr  <= '0;
      gin_wr_data  <= '0;
`ifdef MAX_POOL_CTRL_ZERO_FILL_EN
      gval         <= '0;
`endif
    end else begin
      fm_rd_en   <= 1'b0;
      out_wr_en  <= 1'b0;
      grad_rd_en <= 1'b0;
      gin_wr_en  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            win    <= '0;
            k      <= '0;
            fwd_op <= !mode;
            if (!mode) begin
              state      <= F_READ;
              fm_rd_en   <= 1'b1;
              fm_rd_addr <= in_addr('0, '0);
            end else if (fwd_valid) begin
              state        <= B_READ;
              grad_rd_en   <= 1'b1;
              grad_rd_addr <= '0;
            end else begin
              state <= FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        F_READ: begin
          mx  <= nmx;
          kmx <= nkmx;
          if (k == KW'(S2 - 1)) begin
            state <= F_WAIT;
          end else begin
            k          <= k + 1'b1;
            fm_rd_en   <= 1'b1;
            fm_rd_addr <= in_addr(win, k + 1'b1);
          end
        end
        F_WAIT: begin
          mx          <= nmx;
          kmx         <= nkmx;
          out_wr_en   <= 1'b1;
          out_wr_addr <= win;
          out_wr_data <= nmx;
          state       <= F_WRITE;
        end
        F_WRITE: begin
          if (win == OA'(N - 1)) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            win        <= win + 1'b1;
            k          <= '0;
            state      <= F_READ;
            fm_rd_en   <= 1'b1;
            fm_rd_addr <= in_addr(win + 1'b1, '0);
          end
        end
        B_READ: begin
          state <= B_WAIT;
        end
        B_WAIT: begin
          state     <= B_WRITE;
          k         <= '0;
          gin_wr_en <= 1'b1;
`ifdef MAX_POOL_CTRL_ZERO_FILL_EN
          gval        <= grad_rd_data;
          gin_wr_addr <= in_addr(win, '0);
          gin_wr_data <= (am == '0) ? grad_rd_data : '0;
`else
          gin_wr_addr <= in_addr(win, am);
          gin_wr_data <= grad_rd_data;
`endif
        end
        B_WRITE: begin
`ifdef MAX_POOL_CTRL_ZERO_FILL_EN
          if (k != KW'(S2 - 1)) begin
            k           <= k + 1'b1;
            gin_wr_en   <= 1'b1;
            gin_wr_addr <= in_addr(win, k + 1'b1);
            gin_wr_data <= (am == KW'(k + 1'b1)) ? gval : '0;
          end else if (win == OA'(N - 1)) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            win          <= win + 1'b1;
            state        <= B_READ;
            grad_rd_en   <= 1'b1;
            grad_rd_addr <= win + 1'b1;
          end
`else
          if (win == OA'(N - 1)) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            win          <= win + 1'b1;
            state        <= B_READ;
            grad_rd_en   <= 1'b1;
            grad_rd_addr <= win + 1'b1;
          end
`endif
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (fwd_op)
            fwd_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
